// File: rtl/mul_operand_sequencer.sv
// Front-end for the repeated-addition multiplier: takes an operand pair from a
// valid/ready stream and puts A then B on the shared bus with a start strobe.
// It then waits for done, with a watchdog, and hands the product to a
// valid/ready output stream.
module mul_operand_sequencer #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_data,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_product,
   output logic             out_error,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned   TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StWait, StOut} state_e;

   state_e           r_state;
   state_e           w_state_d;
   logic             r_armed;    // low only until the first edge after reset
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [TW-1:0]    r_timer;
   logic [WIDTH-1:0] r_product;
   logic             r_error;
   logic [CNT_W-1:0] r_count;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_timeout;

   assign w_in_fire  = (r_state == StIdle) && r_armed && in_valid;
   assign w_out_fire = (r_state == StOut) && out_ready;
   assign w_timeout  = (r_timer == TLAST);

   assign out_product = r_product;
   assign out_error   = r_error;
   assign op_count    = r_count;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_state_d = r_state;
      in_ready  = 1'b0;
      mul_start = 1'b0;
      mul_data  = r_b;   // B stays on the bus after LOADB
      out_valid = 1'b0;
      unique case (r_state)
         StIdle: begin
            in_ready = r_armed;
            if (w_in_fire) w_state_d = StLoadA;
         end
         StLoadA: begin
            mul_start = 1'b1;
            mul_data  = r_a;
            w_state_d = StLoadB;
         end
         StLoadB: begin
            mul_start = 1'b1;
            w_state_d = StWait;
         end
         StWait: begin
            if (mul_done || w_timeout) w_state_d = StOut;
         end
         StOut: begin
            out_valid = 1'b1;
            if (out_ready) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Operand capture, watchdog timer, result capture and op counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed   <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_timer   <= '0;
         r_product <= '0;
         r_error   <= 1'b0;
         r_count   <= '0;
      end else begin
         r_armed <= 1'b1;
         if (w_in_fire) begin
            r_a <= in_a;
            r_b <= in_b;
         end
         if (r_state == StLoadB) begin
            r_timer <= '0;
         end else if ((r_state == StWait) && !mul_done && !w_timeout) begin
            r_timer <= r_timer + 1'b1;
         end
         // done wins over a timeout landing on the same cycle
         if (r_state == StWait) begin
            if (mul_done) begin
               r_product <= mul_product;
               r_error   <= 1'b0;
            end else if (w_timeout) begin
               r_product <= '0;
               r_error   <= 1'b1;
            end
         end
         if (w_out_fire && !r_error) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule
